// File: rtl/uart_reg_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the UART register command sequencer.
// Frame layout: byte0 = {rw, addr[6:0]}, optional byte1 = write value.
package uart_reg_ctrl_pkg;

    localparam int unsigned RW_BIT     = 7;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitData = 3'd1,
        StDoWrite  = 3'd2,
        StDoRead   = 3'd3,
        StReadCap  = 3'd4,
        StTxReq    = 3'd5,
        StTxWait   = 3'd6
    } state_e;

    function automatic int unsigned timeout_cycles(input int unsigned frames,
                                                   input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return frames * FRAME_BITS * (clk_hz / bit_rate);
    endfunction

    // Only IDLE and WAIT_DATA consume received bytes; everywhere else they are overruns.
    function automatic logic accepts_rx(input state_e s);
        return (s == StIdle) || (s == StWaitData);
    endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Saturating 32-bit cycle counter with synchronous clear/enable and a terminal-count flag.
module uart_timeout_ctr #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == (CYCLES - 32'd1));

endmodule

// File: rtl/uart_reg_ctrl.sv
// Command sequencer: turns received UART bytes into register writes/reads and returns
// read data through the shared transmitter.
module uart_reg_ctrl
    import uart_reg_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BIT_RATE       = 9600,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              tx_busy_i,
    output logic              tx_en_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wen_o,
    output logic              reg_ren_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic              err_overrun_o
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(TIMEOUT_FRAMES, CLK_HZ, BIT_RATE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_guard_q, tx_guard_d;
    logic              ctr_clr, ctr_en, ctr_tc;

    uart_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (ctr_clr),
        .en_i    (ctr_en),
        .tc_o    (ctr_tc)
    );

    always_comb begin
        state_d       = state_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        tx_data_d     = tx_data_q;
        tx_guard_d    = 1'b0;
        ctr_clr       = 1'b0;
        ctr_en        = 1'b0;
        tx_en_o       = 1'b0;
        reg_wen_o     = 1'b0;
        reg_ren_o     = 1'b0;
        err_timeout_o = 1'b0;
        err_overrun_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid_i) begin
                    reg_addr_d = rx_data_i[ADDR_W-1:0];
                    if (rx_data_i[RW_BIT]) begin
                        state_d = StDoRead;
                    end else begin
                        state_d = StWaitData;
                        ctr_clr = 1'b1;
                    end
                end
            end
            StWaitData: begin
                ctr_en = 1'b1;
                // A data byte landing on the terminal-count cycle still completes the write.
                if (rx_valid_i) begin
                    reg_wdata_d = rx_data_i;
                    state_d     = StDoWrite;
                end else if (ctr_tc) begin
                    err_timeout_o = 1'b1;
                    state_d       = StIdle;
                end
            end
            StDoWrite: begin
                reg_wen_o = 1'b1;
                state_d   = StIdle;
            end
            StDoRead: begin
                reg_ren_o = 1'b1;
                state_d   = StReadCap;
            end
            StReadCap: begin
                tx_data_d = reg_rdata_i;
                state_d   = StTxReq;
            end
            StTxReq: begin
                if (!tx_busy_i) begin
                    tx_en_o    = 1'b1;
                    tx_guard_d = 1'b1;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                // First cycle ignores tx_busy: the transmitter raises it one cycle late.
                if (!tx_guard_q && !tx_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rx_valid_i && !accepts_rx(state_q)) begin
            err_overrun_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_guard_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_guard_q  <= tx_guard_d;
        end
    end

    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl: directed frames plus randomized reads/writes
// checked against a frame-level register-bank model.
module tb_uart_reg_ctrl;

    localparam int unsigned CLK_HZ         = 1000;
    localparam int unsigned BIT_RATE       = 100;
    localparam int unsigned TIMEOUT_FRAMES = 4;
    localparam int unsigned TC             = TIMEOUT_FRAMES * 10 * (CLK_HZ / BIT_RATE);
    localparam int unsigned FRAME_CYC      = 10 * (CLK_HZ / BIT_RATE);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wen;
    logic       reg_ren;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;

    uart_reg_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .BIT_RATE       (BIT_RATE),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .tx_busy_i     (tx_busy),
        .tx_en_o       (tx_en),
        .tx_data_o     (tx_data),
        .reg_addr_o    (reg_addr),
        .reg_wdata_o   (reg_wdata),
        .reg_wen_o     (reg_wen),
        .reg_ren_o     (reg_ren),
        .reg_rdata_i   (reg_rdata),
        .busy_o        (busy),
        .err_timeout_o (err_timeout),
        .err_overrun_o (err_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register bank and transmitter emulation seen by the DUT.
    logic [7:0]  bank [128];
    logic        bank_init = 1'b1;
    int unsigned tx_hold = 5;
    int unsigned tx_cnt = 0;
    int unsigned cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bank_init) begin
            for (int i = 0; i < 128; i++) bank[i] <= 8'(i * 37 + 5);
        end else if (reg_wen) begin
            bank[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_ren ? bank[reg_addr] : 8'($urandom);
        if (reset)              tx_cnt <= 0;
        else if (tx_en)         tx_cnt <= tx_hold;
        else if (tx_cnt != 0)   tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    // Event monitor.
    int          n_wen = 0, n_ren = 0, n_tx = 0, n_tmo = 0, n_ovr = 0;
    logic [7:0]  last_tx = 8'h00;
    int unsigned tmo_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wen) n_wen++;
            if (reg_ren) n_ren++;
            if (tx_en) begin
                n_tx++;
                last_tx = tx_data;
            end
            if (err_timeout) begin
                n_tmo++;
                tmo_cyc = cyc;
            end
            if (err_overrun) n_ovr++;
            if (reg_wen || reg_ren || tx_en)
                check("strobe_exclusive", 32'($countones({reg_wen, reg_ren, tx_en})), 32'd1);
        end
    end

    // Frame-level reference model.
    logic [7:0]  ref_mem [128];
    int          exp_wen = 0, exp_ren = 0, exp_tx = 0, exp_tmo = 0, exp_ovr = 0;
    int unsigned sent_cyc = 0;

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data  = b;
        sent_cyc = cyc;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int unsigned gap);
        int w0 = n_wen;
        int t0 = n_tmo;
        send({1'b0, a});
        repeat (gap) @(posedge clk);
        send(d);
        @(negedge clk);
        check("wen_strobe", 32'(reg_wen), 32'd1);
        check("wen_addr", 32'(reg_addr), 32'(a));
        check("wen_data", 32'(reg_wdata), 32'(d));
        @(posedge clk);
        #1;
        check("wen_count", n_wen, w0 + 1);
        check("no_timeout", n_tmo, t0);
        ref_mem[a] = d;
        exp_wen++;
    endtask

    task automatic do_read(input logic [6:0] a, input int unsigned hold, input logic inject);
        int t0 = n_tx;
        int o0 = n_ovr;
        int k = 0;
        tx_hold = hold;
        send({1'b1, a});
        @(negedge clk);
        check("ren_strobe", 32'(reg_ren), 32'd1);
        check("ren_addr", 32'(reg_addr), 32'(a));
        for (int i = 0; i < 20 && n_tx == t0; i++) @(negedge clk);
        check("tx_count", n_tx, t0 + 1);
        check("tx_data", 32'(last_tx), 32'(ref_mem[a]));
        @(negedge clk);
        check("busy_during_tx", 32'({tx_busy, busy}), 32'd3);
        if (inject) begin
            repeat (20) @(posedge clk);
            send(8'h01);
            check("overrun_pulse", n_ovr, o0 + 1);
            exp_ovr++;
        end
        for (int i = 0; i < int'(hold) + 10 && tx_busy; i++) @(negedge clk);
        check("tx_busy_drop", 32'(tx_busy), 32'd0);
        while (busy && k < 5) begin
            @(negedge clk);
            k++;
        end
        check("busy_fall_delay", k, 1);
        exp_ren++;
        exp_tx++;
    endtask

    initial begin
        int t0;
        int w0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 37 + 5);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 bank_init = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({tx_en, reg_wen, reg_ren, err_timeout, err_overrun}), 32'd0);
        check("rst_regs", 32'({tx_data, reg_addr, reg_wdata}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic write then read-back, then the 0x3C read case.
        do_write(7'h05, 8'h5A, 10);
        check("write_no_tx", n_tx, 0);
        do_read(7'h05, 6, 1'b0);
        do_write(7'h05, 8'h3C, 3);
        do_read(7'h05, 8, 1'b0);

        // Timeout: byte0 then silence.
        t0 = n_tmo;
        w0 = n_wen;
        send(8'h05);
        for (int i = 0; i < int'(TC) + 20 && n_tmo == t0; i++) @(negedge clk);
        check("timeout_count", n_tmo, t0 + 1);
        check("timeout_latency", tmo_cyc - sent_cyc, TC);
        check("timeout_no_wen", n_wen, w0);
        exp_tmo++;
        do_write(7'h06, 8'h11, 4);

        // Data byte on the terminal-count cycle still writes.
        do_write(7'h07, 8'hE2, TC - 2);

        // Overrun while waiting on a long transmission.
        w0 = n_wen;
        t0 = n_tmo;
        do_read(7'h05, 100, 1'b1);
        repeat (TC + 10) @(posedge clk);
        #1;
        check("overrun_not_cmd_tmo", n_tmo, t0);
        check("overrun_not_cmd_wen", n_wen, w0);
        check("overrun_idle", 32'(busy), 32'd0);

        // Reset in the middle of a write frame.
        w0 = n_wen;
        t0 = n_tmo;
        send(8'h05);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(reg_addr), 32'd0);
        do_write(7'h22, 8'h77, 5);
        check("midrst_one_write", n_wen, w0 + 1);
        repeat (TC + 10) @(posedge clk);
        #1;
        check("midrst_no_timeout", n_tmo, t0);
        do_read(7'h05, 4, 1'b0);

        // Back-to-back writes at full line rate.
        for (int i = 0; i < 4; i++) begin
            do_write(7'(8'h41 + i), 8'(8'h31 + i), FRAME_CYC - 2);
            repeat (FRAME_CYC - 3) @(posedge clk);
        end
        for (int i = 0; i < 4; i++) do_read(7'(8'h41 + i), 3, 1'b0);

        // Randomized mix.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(7'($urandom), 8'($urandom), $urandom_range(0, 150));
            else
                do_read(7'($urandom_range(0, 7) + 8'h40), $urandom_range(3, 40), 1'b0);
            repeat ($urandom_range(0, 10)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        check("total_wen", n_wen, exp_wen);
        check("total_ren", n_ren, exp_ren);
        check("total_tx", n_tx, exp_tx);
        check("total_timeout", n_tmo, exp_tmo);
        check("total_overrun", n_ovr, exp_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
